biquad_notch_mc: RTL and testbench
==================================

# biquad_notch_mc

Parametrised, time-multiplexed second-order IIR section (direct form I) serving CHANNELS independent sample streams from one shared multiply-accumulate unit. It is the synthesizable successor to the fixed ideal Notch2 library model. It adds per-channel run-time coefficients, per-channel state history, valid/ready streaming, rounding and saturation. It sits between the sample source and the downstream DSP chain; the coefficient port is driven by the control/register block.

## Interface
- DATA_W, 16: signed sample width
- COEF_W, 18: signed coefficient width
- FRAC, 15: coefficient fractional bits (1.0 = 2^FRAC)
- CHANNELS, 4: number of independent channels (≥1)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  engine can accept a sample
- in_ch  in  $clog2(CHANNELS)  channel of input sample
- in_data  in  DATA_W  signed input sample
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_ch  out  $clog2(CHANNELS)  channel of result
- out_data  out  DATA_W  signed saturated result
- cfg_we  in  1  coefficient write strobe
- cfg_clr  in  1  clear history of cfg_ch
- cfg_ch  in  $clog2(CHANNELS)  target channel
- cfg_idx  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 ignored
- cfg_data  in  COEF_W  signed coefficient
- cfg_ready  out  1  config port can accept a write or clear

## Operation
- Filter: y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2, evaluated per channel.
  - x1, x2, y1, y2 hold that channel's previous inputs and outputs.
- Reset values:
  - coefficients b0 = 2^FRAC, all others 0, so every channel is identity.
  - all history = 0.
  - out_valid = 0, out_data = 0, out_ch = 0, in_ready = 1, cfg_ready = 1.
- FSM states: IDLE, MAC, OUT.
  - IDLE: in_ready = 1. On in_valid, latch in_ch and in_data, clear the accumulator, set k = 0, go to MAC.
  - MAC: one product per cycle, k = 0..4 (b0·x, b1·x1, b2·x2, −a1·y1, −a2·y2). After k = 4:
    - round: add 2^(FRAC−1), then arithmetic shift right by FRAC;
    - saturate to DATA_W;
    - register into out_data and out_ch;
    - update history: x2←x1, x1←x, y2←y1, y1←saturated y;
    - go to OUT.
  - OUT: out_valid = 1. Return to IDLE on out_ready.
- Arithmetic: accumulator width is DATA_W + COEF_W + 3. No overflow is possible inside the accumulator. History stores the saturated y.
- cfg_ready = 1 only in IDLE with in_valid = 0.
  - Writes and clears apply at the clock edge where cfg_ready & (cfg_we | cfg_clr).
  - cfg_clr zeroes x1, x2, y1, y2 of cfg_ch only.
  - cfg_we and cfg_clr in the same cycle: both take effect.
  - In IDLE with both in_valid and a config request, the sample wins and the config is held off.
- in_ch ≥ CHANNELS: the sample is accepted and discarded. No output, no state change.
- Reset mid-operation: immediately returns to the reset values above. Any partial result is dropped.

## Timing
- Sample accepted at edge T (in_valid & in_ready).
- MAC occupies cycles T+1..T+5.
- out_valid rises at T+6. Latency is 6 cycles.
- out_data and out_ch stay stable while out_valid & !out_ready.
- in_ready falls at T and returns the cycle after the output handshake.
- Peak throughput: one sample per 7 cycles.
- A coefficient written at edge C is used by any sample accepted at or after C+1.

## Structure
- Package biquad_pkg:
  - coefficient index enum (B0, B1, B2, A1, A2);
  - FSM state enum;
  - accumulator-width function;
  - sat_round function (round, shift, saturate).
- Sub-module biquad_mac: signed multiplier plus accumulator, with clear/enable and operand select by k. Keeps the FSM and memory in the top module.
- Coefficient and history storage: per-channel register arrays, CHANNELS × 5 coefficients and CHANNELS × 4 history words.

## Test plan
- Reset then ch0 x=1000 → out_data=1000, out_ch=0 exactly 6 cycles after acceptance; in_ready low for 7 cycles.
- Write ch1 b0=16384 (0.5), send ch1 x=2000 → 1000. Then ch0 x=2000 → 2000 (channels independent).
- ch2 a1=−16384: impulse 1000, 0, 0, 0 → 1000, 500, 250, 125. Then cfg_clr ch2 and send 0 → 0.
- ch3 b0=65536 (2.0): x=30000 → 32767, x=−30000 → −32768. History then holds 32767 / −32768.
- ch0 b0=b2=16384, b1=0: input 1000, 0, −1000, 0, 1000, 0, … → from the third output onward, all 0.
- Hold out_ready=0 for 10 cycles → out_data stable, in_ready=0, cfg_ready=0. Assert rst_n=0 during MAC → out_valid=0 and identity coefficients restored.

Source files
------------

// File: rtl/biquad_pkg.sv
// biquad_pkg - shared types and arithmetic helpers for the multi-channel biquad engine.
`default_nettype none

package biquad_pkg;

  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    A1 = 3'd3,
    A2 = 3'd4
  } coef_idx_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int N_COEF = 5;
  localparam int N_HIST = 4;

  // Five products of DATA_W x COEF_W need three guard bits.
  function automatic int acc_width(input int dw, input int cw);
    return dw + cw + 3;
  endfunction

  // Round half up, drop the fractional bits, clip to a dw-bit signed range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int frac, input int dw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi)      sat_round = hi;
    else if (r < lo) sat_round = lo;
    else             sat_round = r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/biquad_mac.sv
// biquad_mac - shared signed multiply-accumulate; term k selects coefficient and operand.
`default_nettype none

module biquad_mac
  import biquad_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int ACC_W  = 37
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr_i,
  input  logic                          en_i,
  input  logic [2:0]                    k_i,
  input  logic [N_COEF-1:0][COEF_W-1:0] coef_i,
  input  logic [N_COEF-1:0][DATA_W-1:0] opnd_i,
  output logic signed [ACC_W-1:0]       acc_o
);

  logic signed [ACC_W-1:0] w_c;
  logic signed [ACC_W-1:0] w_d;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  always_comb begin
    w_c = '0;
    w_d = '0;
    if (k_i < 3'd5) begin
      w_c = ACC_W'($signed(coef_i[k_i]));
      w_d = ACC_W'($signed(opnd_i[k_i]));
    end
    w_prod = w_c * w_d;
    // Feedback terms carry the minus sign of the difference equation.
    acc_d  = (k_i >= A1) ? (acc_q - w_prod) : (acc_q + w_prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/biquad_notch_mc.sv
// biquad_notch_mc - time-multiplexed direct-form-I biquad serving CHANNELS streams
// with per-channel run-time coefficients and history, rounding and saturation.
`default_nettype none

module biquad_notch_mc
  import biquad_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 18,
  parameter int FRAC     = 15,
  parameter int CHANNELS = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     cfg_we,
  input  logic                     cfg_clr,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [2:0]               cfg_idx,
  input  logic signed [COEF_W-1:0] cfg_data,
  output logic                     cfg_ready
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W);
  localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1 << FRAC);

  state_e                    state_q;
  logic [2:0]                k_q;
  logic [CH_W-1:0]           ch_q;
  logic signed [DATA_W-1:0]  x_q;
  logic                      out_valid_q;
  logic [CH_W-1:0]           out_ch_q;
  logic signed [DATA_W-1:0]  out_data_q;

  logic signed [COEF_W-1:0]  coef_q [CHANNELS][N_COEF];
  // History slots: 0 = x1, 1 = x2, 2 = y1, 3 = y2.
  logic signed [DATA_W-1:0]  hist_q [CHANNELS][N_HIST];

  logic [N_COEF-1:0][COEF_W-1:0] w_coef;
  logic [N_COEF-1:0][DATA_W-1:0] w_opnd;
  logic signed [ACC_W-1:0]       w_acc;
  logic signed [DATA_W-1:0]      w_y;
  logic                          w_in_ch_ok;
  logic                          w_cfg_ch_ok;
  logic                          w_accept;
  logic                          w_mac_en;

  generate
    if (CHANNELS == (1 << CH_W)) begin : g_full_range
      assign w_in_ch_ok  = 1'b1;
      assign w_cfg_ch_ok = 1'b1;
    end else begin : g_part_range
      assign w_in_ch_ok  = ({1'b0, in_ch}  < (CH_W + 1)'(CHANNELS));
      assign w_cfg_ch_ok = ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < N_COEF; i++) begin
      w_coef[i] = coef_q[ch_q][i];
    end
    w_opnd[0] = x_q;
    for (int i = 0; i < N_HIST; i++) begin
      w_opnd[i+1] = hist_q[ch_q][i];
    end
  end

  assign w_accept = (state_q == IDLE) && in_valid;
  assign w_mac_en = (state_q == MAC) && (k_q < 3'd5);
  assign w_y      = DATA_W'(sat_round(64'(w_acc), FRAC, DATA_W));

  biquad_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (w_accept),
    .en_i   (w_mac_en),
    .k_i    (k_q),
    .coef_i (w_coef),
    .opnd_i (w_opnd),
    .acc_o  (w_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      ch_q        <= '0;
      x_q         <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < N_COEF; i++) begin
          coef_q[c][i] <= (i == 0) ? UNITY : '0;
        end
        for (int i = 0; i < N_HIST; i++) begin
          hist_q[c][i] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Out-of-range channels are consumed without leaving IDLE.
            if (w_in_ch_ok) begin
              ch_q    <= in_ch;
              x_q     <= in_data;
              k_q     <= '0;
              state_q <= MAC;
            end
          end else if (w_cfg_ch_ok) begin
            if (cfg_we && (cfg_idx < 3'd5)) begin
              coef_q[cfg_ch][cfg_idx] <= cfg_data;
            end
            if (cfg_clr) begin
              for (int i = 0; i < N_HIST; i++) begin
                hist_q[cfg_ch][i] <= '0;
              end
            end
          end
        end
        MAC: begin
          if (k_q == 3'd5) begin
            out_data_q      <= w_y;
            out_ch_q        <= ch_q;
            out_valid_q     <= 1'b1;
            hist_q[ch_q][1] <= hist_q[ch_q][0];
            hist_q[ch_q][0] <= x_q;
            hist_q[ch_q][3] <= hist_q[ch_q][2];
            hist_q[ch_q][2] <= w_y;
            state_q         <= OUT;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign cfg_ready = (state_q == IDLE) && !in_valid;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_biquad_notch_mc.sv
// tb_biquad_notch_mc - directed self-checking bench for biquad_notch_mc.
`default_nettype none

module tb_biquad_notch_mc;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_ch;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_ch;
  logic signed [15:0] out_data;
  logic               cfg_we;
  logic               cfg_clr;
  logic [1:0]         cfg_ch;
  logic [2:0]         cfg_idx;
  logic signed [17:0] cfg_data;
  logic               cfg_ready;

  int n_chk  = 0;
  int n_fail = 0;

  biquad_notch_mc #(
    .DATA_W   (16),
    .COEF_W   (18),
    .FRAC     (15),
    .CHANNELS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_clr   (cfg_clr),
    .cfg_ch    (cfg_ch),
    .cfg_idx   (cfg_idx),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int ch, input int idx, input int data, input bit we, input bit clr);
    @(negedge clk);
    check("cfg_ready_idle", int'(cfg_ready), 1);
    cfg_we   = we;
    cfg_clr  = clr;
    cfg_ch   = 2'(ch);
    cfg_idx  = 3'(idx);
    cfg_data = 18'(data);
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
    cfg_clr = 1'b0;
  endtask

  // Sends one sample with out_ready high; checks result, latency and in_ready low time.
  task automatic send(input int ch, input int x, input int exp_y, input string tag);
    int first;
    int low;
    int d;
    int c;
    first = -1;
    low   = 0;
    d     = 0;
    c     = -1;
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = 2'(ch);
    in_data  = 16'(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid && first < 0) begin
        first = i;
        d     = int'(out_data);
        c     = int'(out_ch);
      end
      if (in_ready) break;
      low++;
      @(posedge clk);
      #1;
    end
    check({tag, "_data"}, d, exp_y);
    check({tag, "_ch"}, c, ch);
    check({tag, "_latency"}, first, 6);
    check({tag, "_busy"}, low, 7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_data   = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_clr   = 1'b0;
    cfg_ch    = '0;
    cfg_idx   = '0;
    cfg_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    rst_n = 1'b1;

    send(0, 1000, 1000, "ident");

    cfg(1, 0, 16384, 1'b1, 1'b0);
    send(1, 2000, 1000, "ch1_half");
    send(0, 2000, 2000, "ch0_indep");

    cfg(2, 3, -16384, 1'b1, 1'b0);
    send(2, 1000, 1000, "imp0");
    send(2, 0, 500, "imp1");
    send(2, 0, 250, "imp2");
    send(2, 0, 125, "imp3");
    cfg(2, 0, 0, 1'b0, 1'b1);
    send(2, 0, 0, "after_clr");

    cfg(3, 0, 65536, 1'b1, 1'b0);
    send(3, 30000, 32767, "sat_pos");
    send(3, -30000, -32768, "sat_neg");
    cfg(3, 0, 0, 1'b1, 1'b0);
    cfg(3, 4, -16384, 1'b1, 1'b0);
    send(3, 0, 16384, "hist_sat");

    cfg(0, 0, 16384, 1'b1, 1'b0);
    cfg(0, 2, 16384, 1'b1, 1'b0);
    send(0, 1000, 1000, "notch0");
    send(0, 0, 1000, "notch1");
    send(0, -1000, 0, "notch2");
    send(0, 0, 0, "notch3");
    send(0, 1000, 0, "notch4");
    send(0, 0, 0, "notch5");

    // Backpressure: result must hold while downstream stalls.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ch     = 2'd0;
    in_data   = 16'sd1000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hold_arrive", int'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_data", int'(out_data), 1000);
      check("hold_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_cfg_ready", int'(cfg_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release", int'(in_ready), 1);

    // Reset in the middle of a ch1 computation.
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = 2'd1;
    in_data  = 16'sd4000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_data", int'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("mid_rst_no_output", int'(out_valid), 0);
    send(1, 2000, 2000, "post_rst_ch1");
    send(3, 3000, 3000, "post_rst_ch3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
